// File: rtl/idli_sqi_mem_m_if.sv
// SQI bus plus backdoor preload port for the SQI-attached byte memory.
interface idli_sqi_mem_m_if #(
  parameter int ADDR_W = 8
);
  logic              i_sqi_sck;
  logic              i_sqi_cs;
  logic [3:0]        i_sqi_sio;
  logic [3:0]        o_sqi_sio;
  logic              o_sqi_oe;
  logic              i_sqi_ld_en;
  logic [ADDR_W-1:0] i_sqi_ld_addr;
  logic [7:0]        i_sqi_ld_data;
  logic              o_sqi_busy;

  modport master (
    output i_sqi_sck, i_sqi_cs, i_sqi_sio, i_sqi_ld_en, i_sqi_ld_addr, i_sqi_ld_data,
    input  o_sqi_sio, o_sqi_oe, o_sqi_busy
  );

  modport slave (
    input  i_sqi_sck, i_sqi_cs, i_sqi_sio, i_sqi_ld_en, i_sqi_ld_addr, i_sqi_ld_data,
    output o_sqi_sio, o_sqi_oe, o_sqi_busy
  );
endinterface

// File: rtl/idli_sqi_mem_m.sv
// SQI slave memory: 0x02 quad write, 0x03 quad read with 2 dummy nibbles,
// SCK/CS oversampled on i_sqi_gck, backdoor preload while idle.
//
// state     | meaning
// IDLE      | deselected; backdoor writes accepted
// CMD       | collecting 2 command nibbles
// ADDR      | collecting 6 address nibbles
// DUMMY     | skipping 2 dummy rises before read data
// RDATA     | driving read nibbles on SCK falls
// WDATA     | assembling write bytes on SCK rises
// IGNORE    | unknown command, wait for deselect
module idli_sqi_mem_m #(
  parameter int ADDR_W = 8
) (
  input logic              i_sqi_gck,
  input logic              i_sqi_rst,
  idli_sqi_mem_m_if.slave  sqi
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_e;

  state_e            state_q, state_d;
  logic              sck_q, sck_qq, cs_q, cs_qq;
  logic [3:0]        sio_q;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        hold_q, hold_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        dout_q, dout_d;
  logic              nib_lo_q, nib_lo_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        rd_byte;
  logic [7:0]        rx_byte;
  logic              rise, fall, sel, sel_edge;
  logic [7:0]        mem_q [2**ADDR_W];

  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      sck_q  <= 1'b0;
      sck_qq <= 1'b0;
      cs_q   <= 1'b1;
      cs_qq  <= 1'b1;
      sio_q  <= '0;
    end else begin
      sck_q  <= sqi.i_sqi_sck;
      sck_qq <= sck_q;
      cs_q   <= sqi.i_sqi_cs;
      cs_qq  <= cs_q;
      sio_q  <= sqi.i_sqi_sio;
    end
  end

  assign rise     = sck_q & ~sck_qq;
  assign fall     = ~sck_q & sck_qq;
  assign sel      = ~cs_q;
  // a CS held low through reset still produces this edge because cs_qq resets high
  assign sel_edge = ~cs_q & cs_qq;
  assign rd_byte  = mem_q[addr_q];
  assign rx_byte  = {hold_q, sio_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    is_rd_d  = is_rd_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    nib_lo_d = nib_lo_q;
    wr_en    = 1'b0;
    wr_addr  = addr_q;
    wr_data  = rx_byte;

    if (state_q != ST_IDLE && !sel) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      nib_lo_d = 1'b0;
      dout_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sqi.i_sqi_ld_en) begin
            wr_en   = 1'b1;
            wr_addr = sqi.i_sqi_ld_addr;
            wr_data = sqi.i_sqi_ld_data;
          end
          if (sel_edge) begin
            state_d = ST_CMD;
            cnt_d   = '0;
            hold_d  = '0;
          end
        end
        ST_CMD: begin
          if (rise) begin
            if (cnt_q == 3'd0) begin
              hold_d = sio_q;
              cnt_d  = 3'd1;
            end else begin
              cnt_d  = '0;
              addr_d = '0;
              case (rx_byte)
                8'h03:   begin state_d = ST_ADDR; is_rd_d = 1'b1; end
                8'h02:   begin state_d = ST_ADDR; is_rd_d = 1'b0; end
                default: state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (rise) begin
            // upper address nibbles simply shift out of the ADDR_W-bit register
            addr_d = ADDR_W'({addr_q, sio_q});
            if (cnt_q == 3'd5) begin
              cnt_d   = '0;
              state_d = is_rd_q ? ST_DUMMY : ST_WDATA;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_DUMMY: begin
          if (rise) begin
            if (cnt_q == 3'd1) begin
              cnt_d    = '0;
              state_d  = ST_RDATA;
              nib_lo_d = 1'b0;
              dout_d   = '0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_RDATA: begin
          if (fall) begin
            dout_d   = nib_lo_q ? rd_byte[3:0] : rd_byte[7:4];
            nib_lo_d = ~nib_lo_q;
            if (nib_lo_q) addr_d = addr_q + ADDR_W'(1);
          end
        end
        ST_WDATA: begin
          if (rise) begin
            if (cnt_q == 3'd0) begin
              hold_d = sio_q;
              cnt_d  = 3'd1;
            end else begin
              wr_en  = 1'b1;
              addr_d = addr_q + ADDR_W'(1);
              cnt_d  = '0;
            end
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      is_rd_q  <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      nib_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      is_rd_q  <= is_rd_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      nib_lo_q <= nib_lo_d;
    end
  end

  // storage is deliberately not reset; reset only blocks writes in its cycle
  always_ff @(posedge i_sqi_gck) begin
    if (!i_sqi_rst && wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign sqi.o_sqi_oe   = (state_q == ST_RDATA);
  assign sqi.o_sqi_sio  = (state_q == ST_RDATA) ? dout_q : 4'h0;
  assign sqi.o_sqi_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Bench for idli_sqi_mem_m: vector table, corner sequences, then random
// transfers checked against a byte-array memory model.
module tb_idli_sqi_mem_m;
  localparam int AW = 8;
  localparam int PH = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idli_sqi_mem_m_if #(.ADDR_W(AW)) bus ();
  idli_sqi_mem_m #(.ADDR_W(AW)) dut (.i_sqi_gck(clk), .i_sqi_rst(rst), .sqi(bus));

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [256];

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          n;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    bus.i_sqi_ld_en   = 1'b1;
    bus.i_sqi_ld_addr = a;
    bus.i_sqi_ld_data = d;
    tick(1);
    bus.i_sqi_ld_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic pulse(input logic [3:0] nib, output logic [3:0] rs, output logic ro);
    bus.i_sqi_sck = 1'b0;
    bus.i_sqi_sio = nib;
    tick(PH);
    rs = bus.o_sqi_sio;
    ro = bus.o_sqi_oe;
    bus.i_sqi_sck = 1'b1;
    tick(PH);
  endtask

  task automatic select();
    bus.i_sqi_cs = 1'b0;
    tick(2);
  endtask

  task automatic deselect();
    bus.i_sqi_sck = 1'b0;
    tick(PH);
    bus.i_sqi_cs = 1'b1;
    tick(4);
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a, output logic oe_seen);
    logic [3:0] s;
    logic o;
    oe_seen = 1'b0;
    pulse(cmd[7:4], s, o); oe_seen |= o;
    pulse(cmd[3:0], s, o); oe_seen |= o;
    for (int i = 5; i >= 0; i--) begin
      pulse(a[4*i +: 4], s, o);
      oe_seen |= o;
    end
  endtask

  task automatic do_write(input logic [23:0] a, input int n, input logic [31:0] data,
                          input bit sel, output logic oe_seen);
    logic [3:0] s;
    logic o;
    logic [7:0] b;
    if (sel) select();
    hdr(8'h02, a, oe_seen);
    for (int i = 0; i < n; i++) begin
      b = data[31-8*i -: 8];
      pulse(b[7:4], s, o); oe_seen |= o | (s != 4'h0);
      pulse(b[3:0], s, o); oe_seen |= o | (s != 4'h0);
    end
    deselect();
    for (int i = 0; i < n; i++) mdl[8'(a[7:0] + 8'(i))] = data[31-8*i -: 8];
  endtask

  task automatic do_read(input logic [23:0] a, input int n, input bit sel,
                         output logic [31:0] got, output logic oe_all, output logic oe_pre);
    logic [3:0] s;
    logic o;
    if (sel) select();
    hdr(8'h03, a, oe_pre);
    pulse(4'(($urandom)), s, o); oe_pre |= o;
    pulse(4'(($urandom)), s, o); oe_pre |= o;
    got = '0;
    oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      pulse(4'h0, s, o); got[31-8*i -: 4] = s; oe_all &= o;
      pulse(4'h0, s, o); got[27-8*i -: 4] = s; oe_all &= o;
    end
    deselect();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic oe_a, oe_p, o;
    logic [3:0] s;
    logic [23:0] ra;
    logic [31:0] rd;
    int rn, op;
    logic [7:0] ix, ex;

    vt[0] = '{8'h02, 24'h000010, 2, 32'hA53C0000, "wr_burst"};
    vt[1] = '{8'h03, 24'h000010, 2, 32'hA53C0000, "rd_after_wr"};
    vt[2] = '{8'h03, 24'h000020, 2, 32'h5AC30000, "rd_preload"};
    vt[3] = '{8'h02, 24'h0000FE, 3, 32'h11223300, "wr_wrap"};
    vt[4] = '{8'h03, 24'h0000FE, 3, 32'h11223300, "rd_wrap"};
    vt[5] = '{8'h03, 24'hFFFF00, 1, 32'h33000000, "rd_upper_bits"};
    vt[6] = '{8'h02, 24'h123440, 1, 32'h9E000000, "wr_upper_bits"};
    vt[7] = '{8'h03, 24'h000040, 1, 32'h9E000000, "rd_40"};
    vt[8] = '{8'h03, 24'h0000FF, 2, 32'h22330000, "rd_ff_wrap"};

    rst = 1'b1;
    bus.i_sqi_sck = 1'b0;
    bus.i_sqi_cs = 1'b1;
    bus.i_sqi_sio = 4'h0;
    bus.i_sqi_ld_en = 1'b0;
    bus.i_sqi_ld_addr = '0;
    bus.i_sqi_ld_data = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_busy", 32'(bus.o_sqi_busy), 32'd0);
    check("reset_oe", 32'(bus.o_sqi_oe), 32'd0);
    check("reset_sio", 32'(bus.o_sqi_sio), 32'd0);

    for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom));
    bd_write(8'h20, 8'h5A);
    bd_write(8'h21, 8'hC3);
    bd_write(8'h50, 8'h01);
    bd_write(8'h60, 8'h0F);
    bd_write(8'h70, 8'hB4);

    for (int i = 0; i < 9; i++) begin
      if (vt[i].cmd == 8'h02) begin
        do_write(vt[i].addr, vt[i].n, vt[i].data, 1'b1, oe_a);
        check({vt[i].name, "_oe_low"}, 32'(oe_a), 32'd0);
      end else begin
        do_read(vt[i].addr, vt[i].n, 1'b1, got, oe_a, oe_p);
        check({vt[i].name, "_data"}, got, vt[i].data);
        check({vt[i].name, "_oe_rdata"}, 32'(oe_a), 32'd1);
        check({vt[i].name, "_oe_hdr"}, 32'(oe_p), 32'd0);
      end
    end

    // backdoor write while a transfer is active must be dropped
    select();
    bus.i_sqi_ld_en = 1'b1; bus.i_sqi_ld_addr = 8'h50; bus.i_sqi_ld_data = 8'hEE;
    tick(1);
    bus.i_sqi_ld_en = 1'b0;
    do_read(24'h000050, 1, 1'b0, got, oe_a, oe_p);
    check("bd_busy_ignored", 32'(got[31:24]), 32'(mdl[8'h50]));

    // select and backdoor write in the same idle cycle
    bus.i_sqi_cs = 1'b0;
    tick(1);
    bus.i_sqi_ld_en = 1'b1; bus.i_sqi_ld_addr = 8'h51; bus.i_sqi_ld_data = 8'h77;
    tick(1);
    bus.i_sqi_ld_en = 1'b0;
    mdl[8'h51] = 8'h77;
    check("sel_bd_busy", 32'(bus.o_sqi_busy), 32'd1);
    do_read(24'h000051, 1, 1'b0, got, oe_a, oe_p);
    check("sel_bd_data", 32'(got[31:24]), 32'h77);

    // bad command then 10 nibbles
    select();
    oe_a = 1'b0;
    pulse(4'h9, s, o); oe_a |= o;
    pulse(4'hF, s, o); oe_a |= o;
    for (int i = 0; i < 10; i++) begin
      pulse(4'($urandom), s, o);
      oe_a |= o | (s != 4'h0);
    end
    check("badcmd_oe", 32'(oe_a), 32'd0);
    bus.i_sqi_sck = 1'b0;
    tick(PH);
    bus.i_sqi_cs = 1'b1;
    tick(1);
    check("badcmd_busy_hold", 32'(bus.o_sqi_busy), 32'd1);
    tick(1);
    check("badcmd_busy_fall", 32'(bus.o_sqi_busy), 32'd0);
    for (int i = 0; i < 4; i++) pulse(4'h3, s, o);
    check("desel_rise_busy", 32'(bus.o_sqi_busy), 32'd0);
    do_read(24'h000020, 2, 1'b1, got, oe_a, oe_p);
    check("badcmd_mem", got, {mdl[8'h20], mdl[8'h21], 16'h0});

    // abort after one write nibble
    select();
    hdr(8'h02, 24'h000060, oe_a);
    pulse(4'h7, s, o);
    deselect();
    do_read(24'h000060, 1, 1'b1, got, oe_a, oe_p);
    check("abort_byte", 32'(got[31:24]), 32'h0F);
    check("abort_next_oe", 32'(oe_a), 32'd1);

    // reset in RDATA with CS held low
    select();
    hdr(8'h03, 24'h000070, oe_a);
    pulse(4'h0, s, o);
    pulse(4'h0, s, o);
    pulse(4'h0, s, o);
    check("rst_pre_nib", 32'(s), 32'hB);
    check("rst_pre_oe", 32'(o), 32'd1);
    bus.i_sqi_sck = 1'b0;
    rst = 1'b1;
    tick(1);
    check("rst_oe", 32'(bus.o_sqi_oe), 32'd0);
    check("rst_sio", 32'(bus.o_sqi_sio), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(3);
    check("rst_cs_low_cmd", 32'(bus.o_sqi_busy), 32'd1);
    do_read(24'h000070, 1, 1'b0, got, oe_a, oe_p);
    check("rst_mem_intact", 32'(got[31:24]), 32'hB4);

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      ra = 24'($urandom);
      rn = $urandom_range(1, 4);
      rd = $urandom;
      if (op == 0) begin
        do_write(ra, rn, rd, 1'b1, oe_a);
        check("rand_wr_oe", 32'(oe_a), 32'd0);
      end else if (op == 1) begin
        do_read(ra, rn, 1'b1, got, oe_a, oe_p);
        for (int i = 0; i < rn; i++) begin
          ix = ra[7:0] + 8'(i);
          ex = mdl[ix];
          check("rand_rd", 32'(got[31-8*i -: 8]), 32'(ex));
        end
        check("rand_rd_oe", 32'(oe_a), 32'd1);
      end else begin
        bd_write(8'($urandom), 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
